snac_joy_scanner: RTL
=====================

# snac_joy_scanner

Parametrised SNAC controller scanner that time-multiplexes up to four Atari-style joystick/paddle-button ports over the user I/O port. It drives port-select lines on `user_out`, waits a settle interval, samples `user_in`, and publishes registered, active-high controller state per port. It sits between the user I/O pins and the console core's player inputs, ahead of the joystick-swap and USB-merge muxing in the top level, and replaces the fixed two-player free-running split toggle.

## Interface
Parameters:
- `NUM_PORTS`, 2 — number of ports scanned, 1..4.
- `SETTLE`, 64 — clk_sys cycles between a select change and the sample, ≥1.
- `DEBOUNCE`, 3 — consecutive identical samples required before an output bit changes, 1..15; used only with `SNAC_DEBOUNCE_EN`.

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  asynchronous reset, active-high.
- `enable`  in  1  scanning enabled (SNAC serial mode selected).
- `num_players`  in  3  requested active ports; 0 is treated as 1; clamped to `NUM_PORTS`.
- `user_in`  in  8  user-port pins, active-low buttons.
- `user_out`  out  8  user-port drive; idle 8'hFF.
- `user_mode`  out  3  user-port mode.
- `joy_out`  out  NUM_PORTS×5  per port {fire, up, down, left, right}, bit 0 = right, active-high.
- `pad_out`  out  NUM_PORTS×2  per port paddle-trigger raw levels, active-low.
- `frame_done`  out  1  one-cycle strobe when all active ports have been updated.

## Operation
- Pin map per sample: right=`user_in[2]`, left=`[1]`, down=`[7]`, up=`[5]`, fire=`[3]`. `joy_out` bits are the inverted pins. `pad_out[0]=user_in[1]`, `pad_out[1]=user_in[2]`, not inverted.
- Select encoding: `user_out[4]=sel[0]`, `user_out[6]=sel[1]`. All other bits are 1.
- When the active port count is 1: both select bits are 1 and `user_mode=3'b000`.
- When the active port count is >1: `user_mode=3'b100`.
- When `enable=0`: `user_out=8'hFF` and `user_mode=3'b000`.
- FSM states:
  - IDLE: `enable=0`. Go to SELECT with port 0 when `enable` rises.
  - SELECT: register `sel=port`, load the settle counter with `SETTLE-1`, go to SETTLE.
  - SETTLE: count down; at 0 go to SAMPLE.
  - SAMPLE: capture `user_in` into the port's sample register, go to UPDATE.
  - UPDATE: write the outputs for that port. If it is the last active port, pulse `frame_done` and wrap to port 0. Otherwise increment the port. Then go to SELECT.
- The active port count is latched at each wrap to port 0. A change to `num_players` mid-frame takes effect on the next frame.
- Deasserting `enable` in any state forces IDLE on the next edge and clears `joy_out`, `pad_out`, and `frame_done` to 0.
- Ports beyond the active count hold `joy_out=0` and `pad_out=2'b11`.
- Counter width is `$clog2(SETTLE)`. The counter does not wrap.

## Timing
- Reset values: `user_out=8'hFF`, `user_mode=0`, `joy_out=0`, `pad_out` all 1s, `frame_done=0`, state IDLE, port 0.
- The select change is visible on the edge after SELECT. The sample is taken on the edge `SETTLE+1` cycles after the select edge. Outputs update one edge after the sample.
- One port slot lasts `SETTLE+3` cycles. One frame lasts active×(`SETTLE+3`).
- `frame_done` is coincident with the output update of the last active port.
- `reset` asserted mid-slot returns all outputs to reset values immediately, with no partial update.

## Configuration
- `SNAC_DEBOUNCE_EN` defined: each output bit of each port has a candidate register and a saturating match counter. The output bit changes only after `DEBOUNCE` consecutive samples that differ from the current output and agree with each other. A disagreeing sample reloads the candidate and resets the count to 1. Debounce state is cleared on disable and on reset.
- `SNAC_DEBOUNCE_EN` not defined: UPDATE copies the sample straight to the outputs. The `DEBOUNCE` parameter is ignored.

## Structure
- Package `snac_pkg` holds:
  - the FSM state enum;
  - pin-index localparams (`PIN_R=2`, `PIN_L=1`, `PIN_D=7`, `PIN_U=5`, `PIN_F=3`, `PIN_SEL0=4`, `PIN_SEL1=6`);
  - `USER_MODE_SNAC=3'b100`.
- Sub-module `snac_debounce`, one instance per port (7 bits wide), is present only under `SNAC_DEBOUNCE_EN`.

## Test plan
- NUM_PORTS=2, SETTLE=4, `num_players=2`, port 0 pins with `user_in[3]=0` and others 1, port 1 all 1s → `joy_out[0]=5'b10000`, `joy_out[1]=0`. `frame_done` pulses every 14 cycles. `user_out` alternates 8'hEF/8'hFF.
- `num_players=1` → `user_out=8'hFF`, `user_mode=0`, only port 0 updates, `frame_done` every 7 cycles.
- `num_players` changed from 2 to 1 mid-slot of port 0 → port 1 is still scanned this frame, and the next frame scans port 0 only.
- `enable` dropped during SETTLE → next edge `user_out=8'hFF`, `user_mode=0`, `joy_out=0`. Re-enable → first update after `SETTLE+3` cycles.
- With `SNAC_DEBOUNCE_EN` and DEBOUNCE=3: a one-sample glitch of `user_in[2]` low does not change the output. Three consecutive low samples → `joy_out[0][0]=1` at the third UPDATE.
- Async `reset` pulse between clock edges mid-frame → all outputs at reset values before the next edge, and the scan restarts at port 0.

Source files
------------

// File: rtl/snac_pkg.sv
// snac_pkg: shared definitions for the SNAC joystick scanner.
//   - snac_state_t : scan FSM states
//   - PIN_*        : user-port pin indices for directions, fire and selects
//   - USER_MODE_*  : user-port mode codes
//   - snac_decode  : turns one raw pin sample into {pad[1:0], joy[4:0]}
package snac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_UPDATE = 3'd4
    } snac_state_t;

    localparam int PIN_R    = 2;
    localparam int PIN_L    = 1;
    localparam int PIN_D    = 7;
    localparam int PIN_U    = 5;
    localparam int PIN_F    = 3;
    localparam int PIN_SEL0 = 4;
    localparam int PIN_SEL1 = 6;

    localparam logic [2:0] USER_MODE_SNAC = 3'b100;
    localparam logic [2:0] USER_MODE_OFF  = 3'b000;

    // Bits [4:0] are {fire, up, down, left, right}, active-high (pins are
    // active-low). Bits [6:5] are the paddle triggers, raw pin levels:
    // pad[0] = left pin, pad[1] = right pin.
    function automatic logic [6:0] snac_decode(input logic [7:0] pins);
        return {pins[PIN_R], pins[PIN_L],
                ~pins[PIN_F], ~pins[PIN_U], ~pins[PIN_D], ~pins[PIN_L], ~pins[PIN_R]};
    endfunction

endpackage

// File: rtl/snac_debounce.sv
// snac_debounce: per-bit sample debouncer for one scanner port.
// Only built when SNAC_DEBOUNCE_EN is defined.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active-high
//   clr  in  synchronous clear of the debounce state (scanner disabled)
//   upd  in  one new sample is being applied this cycle
//   d    in  new sample, WIDTH bits
//   cur  in  currently published value (owned by the scanner)
//   nxt  out value to publish if upd is high
// A bit of nxt differs from cur only after DEBOUNCE consecutive samples
// that differ from cur and agree with each other.
`ifdef SNAC_DEBOUNCE_EN
module snac_debounce #(
    parameter int WIDTH    = 7,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [4:0] DB_LEN = 5'(DEBOUNCE);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic       r_cand;
            logic [3:0] r_cnt;
            logic       w_cand_next;
            logic [3:0] w_cnt_next;
            logic       w_nxt;

            always_comb begin
                w_cand_next = r_cand;
                w_cnt_next  = r_cnt;
                w_nxt       = cur[gi];
                if (d[gi] == cur[gi]) begin
                    // Sample agrees with the output: any pending streak ends.
                    w_cnt_next = 4'd0;
                end else if (r_cnt != 4'd0 && d[gi] == r_cand) begin
                    if (({1'b0, r_cnt} + 5'd1) >= DB_LEN) begin
                        w_nxt      = d[gi];
                        w_cnt_next = 4'd0;
                    end else begin
                        w_cnt_next = r_cnt + 4'd1;
                    end
                end else begin
                    // First differing sample of a new streak.
                    w_cand_next = d[gi];
                    if (DB_LEN <= 5'd1) begin
                        w_nxt      = d[gi];
                        w_cnt_next = 4'd0;
                    end else begin
                        w_cnt_next = 4'd1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cand <= 1'b0;
                    r_cnt  <= 4'd0;
                end else if (clr) begin
                    r_cand <= 1'b0;
                    r_cnt  <= 4'd0;
                end else if (upd) begin
                    r_cand <= w_cand_next;
                    r_cnt  <= w_cnt_next;
                end
            end

            assign nxt[gi] = w_nxt;
        end
    endgenerate

endmodule
`endif

// File: rtl/snac_joy_scanner.sv
// snac_joy_scanner: time-multiplexed SNAC scanner for up to four
// Atari-style joystick ports on the user I/O port.
// Optional feature macro: SNAC_DEBOUNCE_EN (per-bit debounce of samples).
// Ports:
//   clk_sys      in  system clock
//   reset        in  asynchronous reset, active-high
//   enable       in  scanning enabled
//   num_players  in  requested active ports (0 -> 1, clamped to NUM_PORTS)
//   user_in      in  user-port pins, active-low buttons
//   user_out     out user-port drive (port selects on bits 4 and 6)
//   user_mode    out user-port mode
//   joy_out      out per port {fire, up, down, left, right}, active-high
//   pad_out      out per port paddle-trigger raw levels
//   frame_done   out one-cycle strobe after the last active port updates
module snac_joy_scanner #(
    parameter int NUM_PORTS = 2,
    parameter int SETTLE    = 64,
    parameter int DEBOUNCE  = 3
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2:0]             num_players,
    input  logic [7:0]             user_in,
    output logic [7:0]             user_out,
    output logic [2:0]             user_mode,
    output logic [NUM_PORTS*5-1:0] joy_out,
    output logic [NUM_PORTS*2-1:0] pad_out,
    output logic                   frame_done
);
    import snac_pkg::*;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    snac_state_t r_state, w_state_next;

    logic [1:0]             r_port;
    logic [2:0]             r_active;
    logic [CNT_W-1:0]       r_cnt;
    logic [6:0]             r_sample;
    logic [7:0]             r_user_out;
    logic [2:0]             r_user_mode;
    logic [NUM_PORTS*5-1:0] r_joy;
    logic [NUM_PORTS*2-1:0] r_pad;
    logic                   r_frame_done;

    logic [2:0] w_req_active;
    logic       w_last;
    logic [1:0] w_sel;
    logic [7:0] w_sel_out;
    logic [2:0] w_sel_mode;
    logic [6:0] w_port_val;

    always_comb begin
        if (num_players == 3'd0)
            w_req_active = 3'd1;
        else if (num_players > 3'(NUM_PORTS))
            w_req_active = 3'(NUM_PORTS);
        else
            w_req_active = num_players;
    end

    // State register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_SELECT;
                ST_SELECT: w_state_next = ST_SETTLE;
                ST_SETTLE: if (r_cnt == '0) w_state_next = ST_SAMPLE;
                ST_SAMPLE: w_state_next = ST_UPDATE;
                ST_UPDATE: w_state_next = ST_SELECT;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode: select lines, mode, and the value to publish.
    // Select lines not needed by the active count idle high, so a single
    // port drives 2'b11 and two ports leave sel[1] high.
    always_comb begin
        w_last = ({1'b0, r_port} == (r_active - 3'd1));
        w_sel  = r_port;
        if (r_active == 3'd1)
            w_sel = 2'b11;
        else if (r_active == 3'd2)
            w_sel[1] = 1'b1;
        w_sel_out           = 8'hFF;
        w_sel_out[PIN_SEL0] = w_sel[0];
        w_sel_out[PIN_SEL1] = w_sel[1];
        w_sel_mode = (r_active > 3'd1) ? USER_MODE_SNAC : USER_MODE_OFF;
    end

`ifdef SNAC_DEBOUNCE_EN
    logic [6:0] w_deb_nxt [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            if (gi < NUM_PORTS) begin : g_port
                snac_debounce #(
                    .WIDTH    (7),
                    .DEBOUNCE (DEBOUNCE)
                ) u_debounce (
                    .clk (clk_sys),
                    .rst (reset),
                    .clr (!enable),
                    .upd (enable && r_state == ST_UPDATE && r_port == 2'(gi)),
                    .d   (r_sample),
                    .cur ({r_pad[gi*2 +: 2], r_joy[gi*5 +: 5]}),
                    .nxt (w_deb_nxt[gi])
                );
            end else begin : g_none
                assign w_deb_nxt[gi] = 7'b1100000;
            end
        end
    endgenerate

    assign w_port_val = w_deb_nxt[r_port];
`else
    localparam int unused_debounce_cfg = DEBOUNCE;
    assign w_port_val = r_sample;
`endif

    // Datapath and registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_port       <= 2'd0;
            r_active     <= 3'd1;
            r_cnt        <= '0;
            r_sample     <= 7'b1100000;
            r_user_out   <= 8'hFF;
            r_user_mode  <= USER_MODE_OFF;
            r_joy        <= '0;
            r_pad        <= '1;
            r_frame_done <= 1'b0;
        end else if (!enable) begin
            r_port       <= 2'd0;
            r_cnt        <= '0;
            r_user_out   <= 8'hFF;
            r_user_mode  <= USER_MODE_OFF;
            r_joy        <= '0;
            r_pad        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_port   <= 2'd0;
                    r_active <= w_req_active;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (3'(p) >= w_req_active) begin
                            r_joy[p*5 +: 5] <= 5'b00000;
                            r_pad[p*2 +: 2] <= 2'b11;
                        end
                    end
                end
                ST_SELECT: begin
                    r_user_out  <= w_sel_out;
                    r_user_mode <= w_sel_mode;
                    r_cnt       <= CNT_W'(SETTLE - 1);
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_SAMPLE: begin
                    r_sample <= snac_decode(user_in);
                end
                ST_UPDATE: begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (r_port == 2'(p))
                            {r_pad[p*2 +: 2], r_joy[p*5 +: 5]} <= w_port_val;
                    end
                    if (w_last) begin
                        // Frame boundary: the new active count takes effect
                        // here, and ports that drop out are parked.
                        r_frame_done <= 1'b1;
                        r_port       <= 2'd0;
                        r_active     <= w_req_active;
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (3'(p) >= w_req_active) begin
                                r_joy[p*5 +: 5] <= 5'b00000;
                                r_pad[p*2 +: 2] <= 2'b11;
                            end
                        end
                    end else begin
                        r_port <= r_port + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign user_out   = r_user_out;
    assign user_mode  = r_user_mode;
    assign joy_out    = r_joy;
    assign pad_out    = r_pad;
    assign frame_done = r_frame_done;

endmodule
